matmul_tile_arbiter: RTL and testbench
======================================

Name: matmul_tile_arbiter

Overview:
- Shares one fixed_matmul_core_quantized instance between two requesters, e.g. the Q·K^T and score·V streams of an attention layer.
- Grants the core for one whole output tile at a time: IN_DEPTH beats on data_in1 and IN_DEPTH beats on data_in2.
- Grants alternate round-robin between the two requesters.
- Each tile's requester id goes into an in-order tag FIFO, so every core output beat returns to the requester that issued that tile.

Parameters:
IN1_WIDTH, 8, data_in1 element width
IN2_WIDTH, 8, data_in2 (weight) element width
OUT_WIDTH, 8, core output element width
IN1_PARALLELISM, 4, rows per data_in1 beat
IN_SIZE, 1, shared inner dimension per beat
IN2_PARALLELISM, 3, columns per data_in2 beat
IN_DEPTH, 3, beats per operand per tile (>=1)
TAG_DEPTH, 4, maximum tiles in flight (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rK_data_in1  in  IN1_WIDTH x IN1_PARALLELISM*IN_SIZE  requester K operand 1 (K = 0,1, one set per requester)
rK_data_in1_valid / rK_data_in1_ready  in/out  1  handshake for rK_data_in1
rK_data_in2  in  IN2_WIDTH x IN_SIZE*IN2_PARALLELISM  requester K operand 2
rK_data_in2_valid / rK_data_in2_ready  in/out  1  handshake for rK_data_in2
rK_data_out  out  OUT_WIDTH x IN1_PARALLELISM*IN2_PARALLELISM  result returned to requester K
rK_data_out_valid / rK_data_out_ready  out/in  1  handshake for rK_data_out
core_data_in1, core_data_in1_valid, core_data_in1_ready  out/out/in  as above  drive the core's data_in1
core_data_in2, core_data_in2_valid, core_data_in2_ready  out/out/in  as above  drive the core's data_in2
core_data_out, core_data_out_valid, core_data_out_ready  in/in/out  as above  from the core's data_out

Behaviour:
- Reset (async, rst=1): state IDLE, grant id 0, round-robin pointer = 0 (requester 0 has priority), both beat counters 0, tag FIFO empty.
- Outputs during reset: all ready and valid outputs 0. Data outputs are don't-care.
- Reset mid-tile: a partial tile is abandoned. The bench re-resets the core at the same time.

State machine:
- States are IDLE and BUSY.
- Request K = rK_data_in1_valid.
- IDLE -> BUSY when at least one request is active and the tag FIFO is not full.
  - If both requests are active, the round-robin pointer picks the winner.
  - On grant: the winner id is registered, pushed into the tag FIFO, and both counters are cleared.
  - The full test uses the registered FIFO count. A grant is blocked while the FIFO is full, even if a pop occurs in the same cycle.
- BUSY: the granted requester K is connected to the core.
  - core_data_in1 = rK_data_in1.
  - core_data_in1_valid = rK_data_in1_valid && cnt1 < IN_DEPTH.
  - rK_data_in1_ready = core_data_in1_ready && cnt1 < IN_DEPTH.
  - Operand 2 is handled identically with cnt2.
  - Each counter increments on its own handshake.
  - The non-granted requester's readies stay 0. Core valids are 0 in IDLE.
- BUSY -> IDLE in the cycle whose handshake completes the second counter reaching IN_DEPTH. This includes the case where both final handshakes land in the same cycle.
  - The round-robin pointer then moves to the other requester.
  - There is a 1-cycle IDLE bubble between tiles.

Return path:
- head = oldest tag.
- rK_data_out = core_data_out for both K.
- rK_data_out_valid = core_data_out_valid && !tag_empty && head==K.
- core_data_out_ready = r[head]_data_out_ready && !tag_empty.
- The tag pops on a core output handshake, one output beat per tile.
- Pushing and popping in the same cycle is legal when the FIFO is not full.
- core_data_out_valid with an empty FIFO is a protocol error: core_data_out_ready is held 0 and an assertion fires.

Decomposition:
- Package matmul_arb_pkg holds:
  - typedef arb_state_t {IDLE, BUSY};
  - localparam CNT_WIDTH = $clog2(IN_DEPTH+1);
  - localparam TAG_PTR_WIDTH = $clog2(TAG_DEPTH).
- One sub-module, matmul_tag_fifo: a 1-bit wide, TAG_DEPTH deep FIFO.
  - Outputs: full, empty, head.
  - Async active-high reset; push and pop in the same cycle are allowed.

Test Plan:
- r0 only, IN_DEPTH=3, core always ready -> 3 beats on each operand pass through. Grant rises 1 cycle after request. Return to IDLE after the 3rd handshake. The single output goes to r0, and r1 sees valid=0.
- r0 and r1 requesting continuously -> grants alternate r0,r1,r0,r1 with exactly 1 idle cycle between tiles. Outputs return in tag order 0,1,0,1.
- Both requesting, core_data_out_ready path stalled (r0/r1 out_ready=0) -> after TAG_DEPTH=4 grants no further grant. Releasing one output -> one new grant on the following cycle.
- In a tile, data_in2 completes all 3 beats 2 cycles before data_in1 -> rK_data_in2_ready stays 0 after the 3rd beat. The state leaves BUSY only on the 3rd data_in1 handshake.
- rst asserted in BUSY after 1 beat -> all readies and valids drop to 0 immediately (async). After release the tag FIFO is empty and r0 has priority.
- r1 backpressures its output while the head tag is 1 -> core_data_out_ready=0 and r0's result is not delivered ahead of it, so in-order return is preserved.

Source files
------------

// File: rtl/matmul_arb_pkg.sv
// Shared types and default sizing for the matmul core arbiter slice.
package matmul_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_IN_DEPTH  = 3;
    localparam int unsigned ARB_TAG_DEPTH = 4;
    localparam int unsigned CNT_WIDTH     = $clog2(ARB_IN_DEPTH + 1);
    localparam int unsigned TAG_PTR_WIDTH = $clog2(ARB_TAG_DEPTH);

endpackage

// File: rtl/matmul_tag_fifo.sv
// In-order 1-bit tag FIFO recording which requester owns each tile in flight.
module matmul_tag_fifo
    import matmul_arb_pkg::*;
#(
    parameter int unsigned DEPTH     = ARB_TAG_DEPTH,
    parameter int unsigned PTR_WIDTH = TAG_PTR_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam logic [PTR_WIDTH:0] FULL_COUNT = DEPTH[PTR_WIDTH:0];

    logic [DEPTH-1:0]     mem;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH:0]   count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/matmul_tile_arbiter.sv
// Round-robin, tile-granular sharing of one matmul core between two requesters,
// with an in-order tag FIFO steering each result back to its issuer.
module matmul_tile_arbiter
    import matmul_arb_pkg::*;
#(
    parameter int unsigned IN1_WIDTH       = 8,
    parameter int unsigned IN2_WIDTH       = 8,
    parameter int unsigned OUT_WIDTH       = 8,
    parameter int unsigned IN1_PARALLELISM = 4,
    parameter int unsigned IN_SIZE         = 1,
    parameter int unsigned IN2_PARALLELISM = 3,
    parameter int unsigned IN_DEPTH        = ARB_IN_DEPTH,
    parameter int unsigned TAG_DEPTH       = ARB_TAG_DEPTH
) (
    input  logic clk,
    input  logic rst,

    input  logic [IN1_WIDTH*IN1_PARALLELISM*IN_SIZE-1:0]           r0_data_in1,
    input  logic                                                   r0_data_in1_valid,
    output logic                                                   r0_data_in1_ready,
    input  logic [IN2_WIDTH*IN_SIZE*IN2_PARALLELISM-1:0]           r0_data_in2,
    input  logic                                                   r0_data_in2_valid,
    output logic                                                   r0_data_in2_ready,
    output logic [OUT_WIDTH*IN1_PARALLELISM*IN2_PARALLELISM-1:0]   r0_data_out,
    output logic                                                   r0_data_out_valid,
    input  logic                                                   r0_data_out_ready,

    input  logic [IN1_WIDTH*IN1_PARALLELISM*IN_SIZE-1:0]           r1_data_in1,
    input  logic                                                   r1_data_in1_valid,
    output logic                                                   r1_data_in1_ready,
    input  logic [IN2_WIDTH*IN_SIZE*IN2_PARALLELISM-1:0]           r1_data_in2,
    input  logic                                                   r1_data_in2_valid,
    output logic                                                   r1_data_in2_ready,
    output logic [OUT_WIDTH*IN1_PARALLELISM*IN2_PARALLELISM-1:0]   r1_data_out,
    output logic                                                   r1_data_out_valid,
    input  logic                                                   r1_data_out_ready,

    output logic [IN1_WIDTH*IN1_PARALLELISM*IN_SIZE-1:0]           core_data_in1,
    output logic                                                   core_data_in1_valid,
    input  logic                                                   core_data_in1_ready,
    output logic [IN2_WIDTH*IN_SIZE*IN2_PARALLELISM-1:0]           core_data_in2,
    output logic                                                   core_data_in2_valid,
    input  logic                                                   core_data_in2_ready,
    input  logic [OUT_WIDTH*IN1_PARALLELISM*IN2_PARALLELISM-1:0]   core_data_out,
    input  logic                                                   core_data_out_valid,
    output logic                                                   core_data_out_ready
);

    // Counter is never narrower than the package default, and always wide enough for IN_DEPTH.
    localparam int unsigned CW = (CNT_WIDTH > $clog2(IN_DEPTH + 1)) ? CNT_WIDTH : $clog2(IN_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(IN_DEPTH);

    arb_state_t    state;
    logic          grant_id;
    logic          rr_ptr;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;
    logic [CW-1:0] cnt1_nxt;
    logic [CW-1:0] cnt2_nxt;

    logic busy;
    logic req0;
    logic req1;
    logic winner;
    logic grant_fire;
    logic in1_more;
    logic in2_more;
    logic sel_in1_valid;
    logic sel_in2_valid;
    logic hs1;
    logic hs2;
    logic tag_full;
    logic tag_empty;
    logic tag_head;
    logic tag_pop;

    assign busy       = (state == BUSY);
    assign req0       = r0_data_in1_valid;
    assign req1       = r1_data_in1_valid;
    assign winner     = (req0 && req1) ? rr_ptr : req1;
    assign grant_fire = !busy && (req0 || req1) && !tag_full;

    assign in1_more = busy && (cnt1 < DEPTH_C);
    assign in2_more = busy && (cnt2 < DEPTH_C);

    always_comb begin
        core_data_in1 = grant_id ? r1_data_in1 : r0_data_in1;
        core_data_in2 = grant_id ? r1_data_in2 : r0_data_in2;
        sel_in1_valid = grant_id ? r1_data_in1_valid : r0_data_in1_valid;
        sel_in2_valid = grant_id ? r1_data_in2_valid : r0_data_in2_valid;
    end

    assign core_data_in1_valid = in1_more && sel_in1_valid;
    assign core_data_in2_valid = in2_more && sel_in2_valid;
    assign r0_data_in1_ready   = in1_more && core_data_in1_ready && !grant_id;
    assign r1_data_in1_ready   = in1_more && core_data_in1_ready && grant_id;
    assign r0_data_in2_ready   = in2_more && core_data_in2_ready && !grant_id;
    assign r1_data_in2_ready   = in2_more && core_data_in2_ready && grant_id;

    assign hs1      = core_data_in1_valid && core_data_in1_ready;
    assign hs2      = core_data_in2_valid && core_data_in2_ready;
    assign cnt1_nxt = cnt1 + CW'(hs1);
    assign cnt2_nxt = cnt2 + CW'(hs2);

    // Results leave the core in tile order, so the oldest tag owns the current beat.
    assign r0_data_out         = core_data_out;
    assign r1_data_out         = core_data_out;
    assign r0_data_out_valid   = core_data_out_valid && !tag_empty && !tag_head;
    assign r1_data_out_valid   = core_data_out_valid && !tag_empty && tag_head;
    assign core_data_out_ready = !tag_empty && (tag_head ? r1_data_out_ready : r0_data_out_ready);
    assign tag_pop             = core_data_out_valid && core_data_out_ready;

    matmul_tag_fifo #(
        .DEPTH     (TAG_DEPTH),
        .PTR_WIDTH ($clog2(TAG_DEPTH))
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (grant_fire),
        .push_id (winner),
        .pop     (tag_pop),
        .full    (tag_full),
        .empty   (tag_empty),
        .head    (tag_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= 1'b0;
            rr_ptr   <= 1'b0;
            cnt1     <= '0;
            cnt2     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        state    <= BUSY;
                        grant_id <= winner;
                        cnt1     <= '0;
                        cnt2     <= '0;
                    end
                end
                BUSY: begin
                    cnt1 <= cnt1_nxt;
                    cnt2 <= cnt2_nxt;
                    if (cnt1_nxt == DEPTH_C && cnt2_nxt == DEPTH_C) begin
                        state  <= IDLE;
                        rr_ptr <= ~grant_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_no_orphan_output: assert property (@(posedge clk) disable iff (rst)
        !(core_data_out_valid && tag_empty));

endmodule

// File: tb/tb_matmul_tile_arbiter.sv
// Randomized bench: two requester models, a behavioural core model and per-requester result scoreboards.
module tb_matmul_tile_arbiter;

    localparam int IN_DEPTH  = 3;
    localparam int TAG_DEPTH = 4;
    localparam int D1W       = 8 * 4 * 1;
    localparam int D2W       = 8 * 1 * 3;
    localparam int DOW       = 8 * 4 * 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [D1W-1:0] in1_d [2];
    logic           in1_v [2];
    logic           in1_r [2];
    logic [D2W-1:0] in2_d [2];
    logic           in2_v [2];
    logic           in2_r [2];
    logic [DOW-1:0] out_d [2];
    logic           out_v [2];
    logic           out_r [2];
    logic [D1W-1:0] c_in1;
    logic           c_in1_v, c_in1_r;
    logic [D2W-1:0] c_in2;
    logic           c_in2_v, c_in2_r;
    logic [DOW-1:0] c_out;
    logic           c_out_v, c_out_r;

    matmul_tile_arbiter #(
        .IN1_WIDTH(8), .IN2_WIDTH(8), .OUT_WIDTH(8),
        .IN1_PARALLELISM(4), .IN_SIZE(1), .IN2_PARALLELISM(3),
        .IN_DEPTH(IN_DEPTH), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .r0_data_in1(in1_d[0]), .r0_data_in1_valid(in1_v[0]), .r0_data_in1_ready(in1_r[0]),
        .r0_data_in2(in2_d[0]), .r0_data_in2_valid(in2_v[0]), .r0_data_in2_ready(in2_r[0]),
        .r0_data_out(out_d[0]), .r0_data_out_valid(out_v[0]), .r0_data_out_ready(out_r[0]),
        .r1_data_in1(in1_d[1]), .r1_data_in1_valid(in1_v[1]), .r1_data_in1_ready(in1_r[1]),
        .r1_data_in2(in2_d[1]), .r1_data_in2_valid(in2_v[1]), .r1_data_in2_ready(in2_r[1]),
        .r1_data_out(out_d[1]), .r1_data_out_valid(out_v[1]), .r1_data_out_ready(out_r[1]),
        .core_data_in1(c_in1), .core_data_in1_valid(c_in1_v), .core_data_in1_ready(c_in1_r),
        .core_data_in2(c_in2), .core_data_in2_valid(c_in2_v), .core_data_in2_ready(c_in2_r),
        .core_data_out(c_out), .core_data_out_valid(c_out_v), .core_data_out_ready(c_out_r)
    );

    // Requester models: pending beats and the results each requester expects back, in issue order.
    logic [D1W-1:0] q1 [2][$];
    logic [D2W-1:0] q2 [2][$];
    logic [DOW-1:0] expq [2][$];
    bit             hold1 [2];

    // Core model: collects beats, forms a tile result once both operands are complete.
    logic [D1W-1:0] cq1 [$];
    logic [D2W-1:0] cq2 [$];
    logic [DOW-1:0] coutq [$];
    int             coutq_owner [$];
    int             tile_owner_log [$];
    int             deliver_log [$];
    int             start_log [$];
    int             tiles_formed;
    int             c_in1_beats;

    int unsigned gap_pct, cin_rdy_pct, cout_v_pct;
    int unsigned out_rdy_pct [2];
    bit          rst_req;
    int          cyc;
    int          n_checks, n_fail;

    bit s_in1_r [2];
    bit s_in2_r [2];
    bit s_out_v [2];
    bit s_c_in1_v, s_c_in2_v, s_c_out_r;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DOW-1:0] tile_result(input logic [31:0] h1, input logic [31:0] h2);
        return {h2, h1, h1 ^ h2};
    endfunction

    task automatic gen_tile(input int k);
        logic [31:0]    h1, h2, a;
        logic [D2W-1:0] b;
        h1 = '0;
        h2 = '0;
        for (int i = 0; i < IN_DEPTH; i++) begin
            a    = $urandom;
            a[0] = (k == 1);
            b    = D2W'($urandom);
            q1[k].push_back(a);
            q2[k].push_back(b);
            h1 = h1 + a * 32'(i + 1);
            h2 = h2 + 32'(b) * 32'(i + 3);
        end
        expq[k].push_back(tile_result(h1, h2));
    endtask

    task automatic clear_models();
        for (int k = 0; k < 2; k++) begin
            q1[k].delete();
            q2[k].delete();
            expq[k].delete();
            hold1[k] = 1'b0;
        end
        cq1.delete();
        cq2.delete();
        coutq.delete();
        coutq_owner.delete();
        tile_owner_log.delete();
        deliver_log.delete();
        start_log.delete();
        tiles_formed = 0;
        c_in1_beats  = 0;
    endtask

    function automatic bit work_left();
        bit w;
        w = (cq1.size() > 0) || (cq2.size() > 0) || (coutq.size() > 0);
        for (int k = 0; k < 2; k++)
            w = w || (q1[k].size() > 0) || (q2[k].size() > 0) || (expq[k].size() > 0);
        return w;
    endfunction

    task automatic cycle();
        int          owner;
        logic [31:0] h1, h2;
        logic [D1W-1:0] a;
        @(negedge clk);
        rst = rst_req;
        for (int k = 0; k < 2; k++) begin
            in1_v[k] = (q1[k].size() > 0) && !hold1[k] && ($urandom_range(99) >= gap_pct);
            in1_d[k] = (q1[k].size() > 0) ? q1[k][0] : '0;
            in2_v[k] = (q2[k].size() > 0) && ($urandom_range(99) >= gap_pct);
            in2_d[k] = (q2[k].size() > 0) ? q2[k][0] : '0;
            out_r[k] = ($urandom_range(99) < out_rdy_pct[k]);
        end
        c_in1_r = ($urandom_range(99) < cin_rdy_pct);
        c_in2_r = ($urandom_range(99) < cin_rdy_pct);
        c_out_v = (coutq.size() > 0) && ($urandom_range(99) < cout_v_pct);
        c_out   = (coutq.size() > 0) ? coutq[0] : '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            s_in1_r[k] = in1_r[k];
            s_in2_r[k] = in2_r[k];
            s_out_v[k] = out_v[k];
        end
        s_c_in1_v = c_in1_v;
        s_c_in2_v = c_in2_v;
        s_c_out_r = c_out_r;

        check("in1_route", c_in1_v && c_in1_r, (in1_v[0] && in1_r[0]) || (in1_v[1] && in1_r[1]));
        check("in2_route", c_in2_v && c_in2_r, (in2_v[0] && in2_r[0]) || (in2_v[1] && in2_r[1]));
        check("in_ready_excl", (in1_r[0] && in1_r[1]) || (in2_r[0] && in2_r[1]), 1'b0);
        if (c_out_v) begin
            owner = coutq_owner[0];
            check("out_v0", out_v[0], owner == 0);
            check("out_v1", out_v[1], owner == 1);
            check("core_out_rdy", c_out_r, out_r[owner]);
        end else begin
            check("out_v_idle", out_v[0] || out_v[1], 1'b0);
        end

        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (in1_v[k] && in1_r[k]) void'(q1[k].pop_front());
                if (in2_v[k] && in2_r[k]) void'(q2[k].pop_front());
            end
            if (c_in1_v && c_in1_r) begin
                if (c_in1_beats % IN_DEPTH == 0) start_log.push_back(cyc);
                c_in1_beats++;
                cq1.push_back(c_in1);
            end
            if (c_in2_v && c_in2_r) cq2.push_back(c_in2);
            if (c_out_v && c_out_r) begin
                owner = coutq_owner.pop_front();
                check("deliver_hs", out_v[owner] && out_r[owner], 1'b1);
                if (expq[owner].size() == 0)
                    check("deliver_unexpected", 1'b1, 1'b0);
                else
                    check("deliver_data", out_d[owner], expq[owner].pop_front());
                deliver_log.push_back(owner);
                void'(coutq.pop_front());
            end
            if (cq1.size() >= IN_DEPTH && cq2.size() >= IN_DEPTH) begin
                h1    = '0;
                h2    = '0;
                owner = cq1[0][0] ? 1 : 0;
                for (int i = 0; i < IN_DEPTH; i++) begin
                    a  = cq1.pop_front();
                    h1 = h1 + a * 32'(i + 1);
                    h2 = h2 + 32'(cq2.pop_front()) * 32'(i + 3);
                end
                coutq.push_back(tile_result(h1, h2));
                coutq_owner.push_back(owner);
                tile_owner_log.push_back(owner);
                tiles_formed++;
            end
        end
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, {s_in1_r[0], s_in1_r[1], s_in2_r[0], s_in2_r[1]}, 4'b0);
        check({tag, "_core_valid"}, {s_c_in1_v, s_c_in2_v}, 2'b0);
        check({tag, "_out_valid"}, {s_out_v[0], s_out_v[1]}, 2'b0);
        check({tag, "_core_out_rdy"}, s_c_out_r, 1'b0);
    endtask

    task automatic apply_reset();
        clear_models();
        rst_req = 1'b1;
        cycle();
        cycle();
        check_all_zero("rst");
        rst_req = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input string tag);
        int n = 0;
        while (work_left() && n < budget) begin
            cycle();
            n++;
        end
        check(tag, work_left(), 1'b0);
    endtask

    task automatic default_knobs();
        gap_pct        = 0;
        cin_rdy_pct    = 100;
        cout_v_pct     = 100;
        out_rdy_pct[0] = 100;
        out_rdy_pct[1] = 100;
    endtask

    initial begin
        rst      = 1'b1;
        rst_req  = 1'b1;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        default_knobs();
        apply_reset();

        // Single r0 tile: grant one cycle after request, three beats, single result to r0.
        gen_tile(0);
        cycle();
        check("a_idle_ready", s_in1_r[0], 1'b0);
        for (int i = 0; i < IN_DEPTH; i++) begin
            cycle();
            check("a_busy_in1_ready", s_in1_r[0], 1'b1);
            check("a_busy_in2_ready", s_in2_r[0], 1'b1);
        end
        cycle();
        check("a_back_idle", {s_in1_r[0], s_in2_r[0]}, 2'b0);
        check("a_out_r0", s_out_v[0], 1'b1);
        check("a_out_r1", s_out_v[1], 1'b0);
        run_until_done(50, "a_done");
        check("a_tiles", tiles_formed, 1);

        // Both requesting continuously: alternating grants, one-cycle bubble, in-order returns.
        apply_reset();
        for (int t = 0; t < 4; t++) begin
            gen_tile(0);
            gen_tile(1);
        end
        run_until_done(200, "b_done");
        check("b_tiles", tile_owner_log.size(), 8);
        for (int i = 0; i < tile_owner_log.size(); i++)
            check("b_grant_order", tile_owner_log[i], i % 2);
        for (int i = 0; i < deliver_log.size(); i++)
            check("b_return_order", deliver_log[i], i % 2);
        for (int i = 1; i < start_log.size(); i++)
            check("b_tile_period", start_log[i] - start_log[i-1], IN_DEPTH + 1);

        // Output path stalled: grants stop at TAG_DEPTH, one pop allows exactly one more.
        apply_reset();
        out_rdy_pct[0] = 0;
        out_rdy_pct[1] = 0;
        for (int t = 0; t < 4; t++) begin
            gen_tile(0);
            gen_tile(1);
        end
        repeat (60) cycle();
        check("c_tiles_at_full", tiles_formed, TAG_DEPTH);
        check("c_blocked_in1", s_in1_r[0] || s_in1_r[1], 1'b0);
        check("c_head_owner", coutq_owner[0], 0);
        out_rdy_pct[0] = 100;
        cycle();
        check("c_popped", deliver_log.size(), 1);
        out_rdy_pct[0] = 0;
        cycle();
        check("c_still_idle", s_in1_r[0] || s_in1_r[1], 1'b0);
        cycle();
        check("c_regrant_r0", s_in1_r[0], 1'b1);
        repeat (30) cycle();
        check("c_tiles_refull", tiles_formed, TAG_DEPTH + 1);
        default_knobs();
        run_until_done(300, "c_done");

        // Operand 2 finishes early; BUSY persists until the last operand 1 beat.
        apply_reset();
        gen_tile(0);
        gen_tile(0);
        cycle();
        cycle();
        check("d_beat1_in2", s_in2_r[0], 1'b1);
        hold1[0] = 1'b1;
        cycle();
        cycle();
        check("d_in2_third_beat", s_in2_r[0], 1'b1);
        hold1[0] = 1'b0;
        cycle();
        check("d_in2_done_ready", s_in2_r[0], 1'b0);
        check("d_in2_done_core_v", s_c_in2_v, 1'b0);
        check("d_in1_still_busy", s_in1_r[0], 1'b1);
        cycle();
        check("d_in2_done_ready2", s_in2_r[0], 1'b0);
        check("d_in1_last", s_in1_r[0], 1'b1);
        cycle();
        check("d_left_busy", s_in1_r[0], 1'b0);
        run_until_done(100, "d_done");

        // Reset mid-tile while r1 is granted: everything drops, r0 regains priority.
        apply_reset();
        gen_tile(0);
        run_until_done(50, "e_pre_done");
        gen_tile(1);
        cycle();
        cycle();
        check("e_r1_busy", s_in1_r[1], 1'b1);
        rst_req = 1'b1;
        cycle();
        check_all_zero("e_mid_rst");
        clear_models();
        cycle();
        rst_req = 1'b0;
        gen_tile(1);
        gen_tile(0);
        run_until_done(100, "e_done");
        check("e_first_owner", tile_owner_log[0], 0);
        check("e_second_owner", tile_owner_log[1], 1);

        // Random valid gaps and backpressure on every channel.
        apply_reset();
        gap_pct        = 30;
        cin_rdy_pct    = 70;
        cout_v_pct     = 60;
        out_rdy_pct[0] = 55;
        out_rdy_pct[1] = 45;
        for (int t = 0; t < 8; t++) begin
            gen_tile(0);
            gen_tile(1);
        end
        run_until_done(4000, "f_done");
        check("f_tiles", tiles_formed, 16);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
